// File: rtl/lmb_bram_port_arbiter.sv
// Shares one LMB data BRAM port between two local requesters (M0, M1) with
// round-robin or fixed-priority arbitration and an optional post-reset fill.
module lmb_bram_port_arbiter #(
   parameter int unsigned C_MEMSIZE        = 'h8000,
   parameter int unsigned C_PORT_DWIDTH    = 32,
   parameter int unsigned C_PORT_AWIDTH    = 32,
   parameter int unsigned C_NUM_WE         = 4,
   parameter int unsigned C_FIXED_PRIORITY = 0,
   parameter int unsigned C_INIT_ON_RESET  = 0,
   parameter logic [C_PORT_DWIDTH-1:0] C_INIT_VALUE = 32'h00000000
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   output logic                     Init_Done,
   input  logic                     M0_Req,
   input  logic                     M0_RNW,
   input  logic [C_PORT_AWIDTH-1:0] M0_Addr,
   input  logic [C_PORT_DWIDTH-1:0] M0_WrData,
   input  logic [C_NUM_WE-1:0]      M0_BE,
   output logic                     M0_Ack,
   output logic [C_PORT_DWIDTH-1:0] M0_RdData,
   output logic                     M0_RdValid,
   input  logic                     M1_Req,
   input  logic                     M1_RNW,
   input  logic [C_PORT_AWIDTH-1:0] M1_Addr,
   input  logic [C_PORT_DWIDTH-1:0] M1_WrData,
   input  logic [C_NUM_WE-1:0]      M1_BE,
   output logic                     M1_Ack,
   output logic [C_PORT_DWIDTH-1:0] M1_RdData,
   output logic                     M1_RdValid,
   output logic                     BRAM_EN,
   output logic [C_NUM_WE-1:0]      BRAM_WEN,
   output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
   output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
   input  logic [C_PORT_DWIDTH-1:0] BRAM_Din
);

   typedef enum logic [1:0] {
      ST_RST_EXIT = 2'd0,
      ST_INIT     = 2'd1,
      ST_IDLE     = 2'd2
   } state_t;

   localparam int unsigned WORDS = C_MEMSIZE / 4;
   localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

   state_t                     state_q, state_d;
   logic [WCW-1:0]             word_q, word_d;
   logic                       init_done_q, init_done_d;
   logic                       last_grant_q, last_grant_d;   // 0 = M0, 1 = M1
   logic [1:0]                 ack_q, ack_d;
   logic [1:0]                 rd_issue_q, rd_issue_d;
   logic [1:0]                 rd_valid_q, rd_valid_d;
   logic                       en_q, en_d;
   logic [C_NUM_WE-1:0]        wen_q, wen_d;
   logic [C_PORT_AWIDTH-1:0]   addr_q, addr_d;
   logic [C_PORT_DWIDTH-1:0]   dout_q, dout_d;

   logic [1:0]                 elig;
   logic [1:0]                 grant;
   logic                       sel_rnw;
   logic [C_PORT_AWIDTH-1:0]   sel_addr;
   logic [C_PORT_DWIDTH-1:0]   sel_wd;
   logic [C_NUM_WE-1:0]        sel_be;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{M0_Addr[1:0], M1_Addr[1:0]};

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      init_done_d  = init_done_q;
      last_grant_d = last_grant_q;
      ack_d        = 2'b00;
      rd_issue_d   = 2'b00;
      rd_valid_d   = rd_issue_q;
      en_d         = 1'b0;
      wen_d        = '0;
      addr_d       = addr_q;
      dout_d       = dout_q;
      // A requester is masked in its own Ack cycle, its Req is still the old one
      elig         = {M1_Req, M0_Req} & ~ack_q;
      grant        = 2'b00;
      sel_rnw      = 1'b0;
      sel_addr     = '0;
      sel_wd       = '0;
      sel_be       = '0;

      unique case (state_q)
         ST_RST_EXIT: begin
            if (C_INIT_ON_RESET != 0) begin
               state_d = ST_INIT;
               word_d  = '0;
               en_d    = 1'b1;
               wen_d   = '1;
               addr_d  = '0;
               dout_d  = C_INIT_VALUE;
            end else begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_INIT: begin
            if (word_q == LAST_WORD) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               word_d = word_q + 1'b1;
               en_d   = 1'b1;
               wen_d  = '1;
               addr_d = C_PORT_AWIDTH'(word_d) << 2;
               dout_d = C_INIT_VALUE;
            end
         end
         ST_IDLE: begin
            if (elig == 2'b11)
               grant = ((C_FIXED_PRIORITY != 0) || last_grant_q) ? 2'b01 : 2'b10;
            else
               grant = elig;

            sel_rnw  = grant[1] ? M1_RNW    : M0_RNW;
            sel_addr = grant[1] ? M1_Addr   : M0_Addr;
            sel_wd   = grant[1] ? M1_WrData : M0_WrData;
            sel_be   = grant[1] ? M1_BE     : M0_BE;

            if (grant != 2'b00) begin
               ack_d        = grant;
               en_d         = 1'b1;
               wen_d        = sel_rnw ? '0 : sel_be;
               addr_d       = {sel_addr[C_PORT_AWIDTH-1:2], 2'b00};
               dout_d       = sel_wd;
               rd_issue_d   = grant & {2{sel_rnw}};
               last_grant_d = grant[1];
            end
         end
         default: state_d = ST_RST_EXIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q      <= ST_RST_EXIT;
         word_q       <= '0;
         init_done_q  <= 1'b0;
         last_grant_q <= 1'b1;
         ack_q        <= 2'b00;
         rd_issue_q   <= 2'b00;
         rd_valid_q   <= 2'b00;
         en_q         <= 1'b0;
         wen_q        <= '0;
         addr_q       <= '0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         init_done_q  <= init_done_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         rd_issue_q   <= rd_issue_d;
         rd_valid_q   <= rd_valid_d;
         en_q         <= en_d;
         wen_q        <= wen_d;
         addr_q       <= addr_d;
         dout_q       <= dout_d;
      end
   end

   assign Init_Done  = init_done_q;
   assign M0_Ack     = ack_q[0];
   assign M1_Ack     = ack_q[1];
   assign M0_RdValid = rd_valid_q[0];
   assign M1_RdValid = rd_valid_q[1];
   assign M0_RdData  = BRAM_Din;
   assign M1_RdData  = BRAM_Din;
   assign BRAM_EN    = en_q;
   assign BRAM_WEN   = wen_q;
   assign BRAM_Addr  = addr_q;
   assign BRAM_Dout  = dout_q;

endmodule

// File: tb/tb_lmb_bram_port_arbiter.sv
// Bench: round-robin/fill instance (dut 0) and fixed-priority instance (dut 1),
// each with its own BRAM model, checked against a cycle-level reference model.
module tb_lmb_bram_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic [1:0][1:0]         req, rnw;
   logic [1:0][1:0][31:0]   addr, wd;
   logic [1:0][1:0][3:0]    be;

   logic [1:0]              done_o, en_o;
   logic [1:0][1:0]         ack_o, rv_o;
   logic [1:0][1:0][31:0]   rd_o;
   logic [1:0][3:0]         wen_o;
   logic [1:0][31:0]        baddr_o, bdout_o, bdin;

   lmb_bram_port_arbiter #(
      .C_MEMSIZE('h40), .C_FIXED_PRIORITY(0), .C_INIT_ON_RESET(1), .C_INIT_VALUE(32'hDEADBEEF)
   ) dut_rr (
      .Clk(clk), .Rst_n(rst_n), .Init_Done(done_o[0]),
      .M0_Req(req[0][0]), .M0_RNW(rnw[0][0]), .M0_Addr(addr[0][0]), .M0_WrData(wd[0][0]),
      .M0_BE(be[0][0]), .M0_Ack(ack_o[0][0]), .M0_RdData(rd_o[0][0]), .M0_RdValid(rv_o[0][0]),
      .M1_Req(req[0][1]), .M1_RNW(rnw[0][1]), .M1_Addr(addr[0][1]), .M1_WrData(wd[0][1]),
      .M1_BE(be[0][1]), .M1_Ack(ack_o[0][1]), .M1_RdData(rd_o[0][1]), .M1_RdValid(rv_o[0][1]),
      .BRAM_EN(en_o[0]), .BRAM_WEN(wen_o[0]), .BRAM_Addr(baddr_o[0]),
      .BRAM_Dout(bdout_o[0]), .BRAM_Din(bdin[0])
   );

   lmb_bram_port_arbiter #(
      .C_MEMSIZE('h40), .C_FIXED_PRIORITY(1), .C_INIT_ON_RESET(0), .C_INIT_VALUE(32'h00000000)
   ) dut_fp (
      .Clk(clk), .Rst_n(rst_n), .Init_Done(done_o[1]),
      .M0_Req(req[1][0]), .M0_RNW(rnw[1][0]), .M0_Addr(addr[1][0]), .M0_WrData(wd[1][0]),
      .M0_BE(be[1][0]), .M0_Ack(ack_o[1][0]), .M0_RdData(rd_o[1][0]), .M0_RdValid(rv_o[1][0]),
      .M1_Req(req[1][1]), .M1_RNW(rnw[1][1]), .M1_Addr(addr[1][1]), .M1_WrData(wd[1][1]),
      .M1_BE(be[1][1]), .M1_Ack(ack_o[1][1]), .M1_RdData(rd_o[1][1]), .M1_RdValid(rv_o[1][1]),
      .BRAM_EN(en_o[1]), .BRAM_WEN(wen_o[1]), .BRAM_Addr(baddr_o[1]),
      .BRAM_Dout(bdout_o[1]), .BRAM_Din(bdin[1])
   );

   // BE bit j enables byte lane [31-8j -: 8] (bit 0 = most significant byte)
   function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] bev);
      logic [31:0] r;
      r = old_w;
      for (int j = 0; j < 4; j++)
         if (bev[j]) r[31-8*j -: 8] = new_w[31-8*j -: 8];
      return r;
   endfunction

   bit [31:0] bmem [2][256];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (en_o[k]) begin
            bdin[k] <= bmem[k][baddr_o[k][9:2]];
            bmem[k][baddr_o[k][9:2]] <= merge_be(bmem[k][baddr_o[k][9:2]], bdout_o[k], wen_o[k]);
         end
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mode = 0;   // 0 directed, 1 random traffic, 2 continuous traffic

   int        c      [2];
   int        lg     [2];
   bit        cur_ack[2][2];
   bit        cur_rd [2][2];
   bit [31:0] cur_rdd[2][2];
   bit [31:0] ref_mem[2][256];
   bit        e_done [2];
   bit        e_en   [2];
   bit        e_bus  [2];
   bit [3:0]  e_wen  [2];
   bit [31:0] e_addr [2];
   bit [31:0] e_dout [2];
   bit        e_ack  [2][2];
   bit        e_rv   [2][2];
   bit [31:0] e_rdd  [2][2];

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
      end
   endtask

   // Predicts outputs of the next cycle from this cycle's inputs and history.
   task automatic predict();
      for (int k = 0; k < 2; k++) begin
         int        n_words;
         int        win;
         bit        el0, el1, done_now;
         bit        nrd  [2];
         bit [31:0] nrdd [2];
         n_words = (k == 0) ? 16 : 0;
         win = -1;
         e_en[k] = 0; e_wen[k] = 0; e_addr[k] = 0; e_dout[k] = 0; e_bus[k] = 0;
         for (int i = 0; i < 2; i++) begin
            e_ack[k][i] = 0; e_rv[k][i] = 0; e_rdd[k][i] = 0; nrd[i] = 0; nrdd[i] = 0;
         end
         if (!rst_n) begin
            c[k] = 0; lg[k] = 1; e_done[k] = 0; e_bus[k] = 1;
         end else begin
            done_now  = (c[k] >= n_words + 1);
            e_done[k] = (c[k] + 1 >= n_words + 1);
            if (c[k] < n_words) begin
               e_en[k] = 1; e_bus[k] = 1; e_wen[k] = 4'hF;
               e_addr[k] = 32'(4 * c[k]); e_dout[k] = 32'hDEADBEEF;
               ref_mem[k][c[k]] = 32'hDEADBEEF;
            end
            if (done_now) begin
               el0 = req[k][0] && !cur_ack[k][0];
               el1 = req[k][1] && !cur_ack[k][1];
               if (el0 && el1) win = (k == 1) ? 0 : ((lg[k] == 0) ? 1 : 0);
               else if (el0)   win = 0;
               else if (el1)   win = 1;
            end
            if (win >= 0) begin
               e_ack[k][win] = 1; e_en[k] = 1; e_bus[k] = 1;
               e_wen[k]  = rnw[k][win] ? 4'h0 : be[k][win];
               e_addr[k] = addr[k][win] & ~32'h3;
               e_dout[k] = wd[k][win];
               lg[k] = win;
               if (rnw[k][win]) begin
                  nrd[win]  = 1;
                  nrdd[win] = ref_mem[k][addr[k][win][9:2]];
               end else begin
                  ref_mem[k][addr[k][win][9:2]] =
                     merge_be(ref_mem[k][addr[k][win][9:2]], wd[k][win], be[k][win]);
               end
            end
            for (int i = 0; i < 2; i++) begin
               e_rv[k][i] = cur_rd[k][i]; e_rdd[k][i] = cur_rdd[k][i];
            end
            if (c[k] < 100000) c[k]++;
         end
         for (int i = 0; i < 2; i++) begin
            cur_ack[k][i] = e_ack[k][i]; cur_rd[k][i] = nrd[i]; cur_rdd[k][i] = nrdd[i];
         end
      end
   endtask

   task automatic check();
      for (int k = 0; k < 2; k++) begin
         chk("init_done", k, 32'(done_o[k]), 32'(e_done[k]));
         chk("bram_en",   k, 32'(en_o[k]),   32'(e_en[k]));
         chk("bram_wen",  k, 32'(wen_o[k]),  32'(e_wen[k]));
         chk("dual_ack",  k, 32'(ack_o[k][0] & ack_o[k][1]), 32'd0);
         if (e_bus[k]) begin
            chk("bram_addr", k, baddr_o[k], e_addr[k]);
            chk("bram_dout", k, bdout_o[k], e_dout[k]);
         end
         for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "m0_ack" : "m1_ack", k, 32'(ack_o[k][i]), 32'(e_ack[k][i]));
            chk(i == 0 ? "m0_rdvalid" : "m1_rdvalid", k, 32'(rv_o[k][i]), 32'(e_rv[k][i]));
            if (e_rv[k][i])
               chk(i == 0 ? "m0_rddata" : "m1_rddata", k, rd_o[k][i], e_rdd[k][i]);
         end
      end
   endtask

   task automatic new_txn(input int k, input int i, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
      req[k][i] = 1'b1; rnw[k][i] = r; addr[k][i] = a; wd[k][i] = d; be[k][i] = b;
   endtask

   // A master drops Req after its Ack; in traffic modes it may start a new one at once.
   task automatic update_masters();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 2; i++) begin
            if (req[k][i] && cur_ack[k][i]) req[k][i] = 1'b0;
            if (!req[k][i] && mode != 0 && (mode == 2 || $urandom_range(0, 2) == 0))
               new_txn(k, i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
                       32'($urandom), 4'($urandom_range(0, 15)));
         end
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      #1;
      cyc++;
      check();
      update_masters();
      $display("cyc=%0d rst_n=%0b dut0 ack=%b rv=%b en=%b addr=%h | dut1 ack=%b rv=%b en=%b addr=%h",
               cyc, rst_n, ack_o[0], rv_o[0], en_o[0], baddr_o[0], ack_o[1], rv_o[1], en_o[1], baddr_o[1]);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      mode = 0;
      while ((req != '0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 0, 32'(req), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; rnw = '0; addr = '0; wd = '0; be = '0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      // requests raised during the fill of dut 0
      for (int k = 0; k < 2; k++) new_txn(k, 0, 1'b0, 32'h104, 32'hAABBCCDD, 4'b1111);
      drain(40);
      for (int k = 0; k < 2; k++) new_txn(k, 0, 1'b0, 32'h104, 32'h11223344, 4'b0101);
      drain(10);
      for (int k = 0; k < 2; k++) new_txn(k, 0, 1'b1, 32'h107, 32'h0, 4'b0000);
      drain(10);
      repeat (3) step();
      for (int k = 0; k < 2; k++) new_txn(k, 1, 1'b0, 32'h20, 32'h55667788, 4'b0000);
      drain(10);
      for (int k = 0; k < 2; k++) new_txn(k, 1, 1'b1, 32'h20, 32'h0, 4'b0000);
      drain(10);
      repeat (3) step();
      // both masters continuously requesting
      for (int k = 0; k < 2; k++) begin
         new_txn(k, 0, 1'b1, 32'h8, 32'h0, 4'h0);
         new_txn(k, 1, 1'b0, 32'h30C, 32'hCAFEF00D, 4'hF);
      end
      mode = 2;
      repeat (20) step();
      drain(10);
      mode = 1;
      repeat (400) step();
      drain(20);
      repeat (3) step();
      // reset during the cycle before RdValid
      for (int k = 0; k < 2; k++) new_txn(k, 0, 1'b1, 32'h104, 32'h0, 4'h0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (6) step();
      // reset in the middle of the fill, which then restarts from word 0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (25) step();
      mode = 1;
      repeat (100) step();
      drain(20);
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
